conv2d_stream: RTL and testbench
================================

// Module: conv2d_stream
// PURPOSE
//   Streaming KxK 2-D convolution over raster-order pixel frames, generalising the fixed 3x3 edge filter.
//   Kernel size, widths and frame size are parameters. Coefficients are runtime-loadable and double-buffered.
//   Pixels arrive with a valid qualifier, and the output shift is programmable.
//   Sits between the pixel source and the downstream CNN stages.
//   Emits one valid-mode output per full window (no padding), with end-of-frame marking.
// PARAMETERS
//   WORD_SIZE   8   unsigned pixel width (input and output)
//   COEF_WIDTH  8   signed coefficient width
//   KSIZE       3   kernel side K (odd, >=3)
//   ROW_SIZE    10  pixels per row
//   COL_SIZE    10  rows per frame
// PORTS
//   clk          in   1                  clock
//   rst          in   1                  reset: synchronous, active-high
//   in_valid     in   1                  in_pixel accepted on this edge
//   in_pixel     in   WORD_SIZE          unsigned pixel, raster order
//   coef_we      in   1                  write coef_data into shadow bank at coef_addr
//   coef_addr    in   clog2(K*K)         row-major index r*K+c
//   coef_data    in   COEF_WIDTH         signed coefficient
//   coef_commit  in   1                  pulse: request shadow->active copy
//   shift        in   clog2(ACC_W)       arithmetic right shift applied before clamping
//   out_valid    out  1                  out_pixel valid
//   out_pixel    out  WORD_SIZE          clamped result
//   out_eof      out  1                  with out_valid on the last output of a frame
//   coef_pending out  1                  commit requested, swap not yet done
// BEHAVIOUR
// - ACC_W = WORD_SIZE+COEF_WIDTH+clog2(K*K)+1, signed. All products and sums are computed at full width; no overflow is possible.
// - Buffering: K-1 line buffers of ROW_SIZE words, plus a KxK window register.
//   All of these advance only on in_valid.
// - Counters: col in 0..ROW_SIZE-1 and row in 0..COL_SIZE-1, both incremented on in_valid.
//   col wraps to 0 and increments row; at (COL_SIZE-1, ROW_SIZE-1) both wrap to 0 (next frame).
// - A window is valid when the accepted pixel has row>=K-1 and col>=K-1. Windows never straddle rows or frames.
//   Outputs per frame = (ROW_SIZE-K+1)*(COL_SIZE-K+1).
// - Pipeline (free-running, not stalled by in_valid gaps), with a valid bit per stage:
//   - edge 0: pixel accepted, window updated
//   - edge 1: K*K products registered
//   - edge 2: sum registered
//   - edge 3: shift and clamp into out_pixel
//   Latency is 3 cycles from the accepting edge to out_valid high.
// - Result: v = sum >>> shift (arithmetic), then out_pixel = (v<0)?0 : (v>2^WORD_SIZE-1)?max : v[WORD_SIZE-1:0].
//   shift is sampled at edge 3.
// - Boundary conditions:
//   - out_eof=1 only for the window at row=COL_SIZE-1, col=ROW_SIZE-1.
//   - out_valid and out_eof are 0 otherwise; out_pixel holds its last value when out_valid=0.
// - Coefficients:
//   - coef_we writes the shadow bank only; the active bank is used by the products at edge 1.
//   - coef_commit while row=col=0: copy on that edge; coef_pending stays 0.
//   - coef_commit mid-frame: coef_pending=1; the copy happens on the edge that accepts the last pixel of the frame; coef_pending then clears.
//   - Pipeline data still in flight keeps the products it already computed.
//   - coef_we and the copy in the same cycle: the copy takes the pre-write shadow value; the write lands in shadow.
//   - Repeated commits while pending have no additional effect.
// - Reset (also mid-frame), effective at the next edge:
//   - Clears counters and all pipeline valids; out_valid=0, out_eof=0, out_pixel=0, coef_pending=0.
//   - Both banks load the default kernel: centre=K*K-1, all others -1.
//   - Line-buffer contents are don't-care, since validity is gated by the counters.
// TESTING (K=3, 10x10 unless stated)
// - After reset, constant frame of 100s -> exactly 64 out_valid pulses, all out_pixel=0; out_eof on the 64th only.
// - Single 255 at (row 5, col 5), zeros elsewhere, shift=0:
//   - Window centred on it -> 2040, clamped to 255.
//   - 8 neighbour windows -> -255, clamped to 0.
// - Load all nine coefficients =1, commit at idle, shift=3, constant 80 -> every output = 720>>>3 = 90.
// - Commit all-ones mid-frame:
//   - The remainder of that frame uses the Laplacian (output 0).
//   - coef_pending is high until the last pixel; the next frame outputs 90.
// - Random in_valid gaps (50% duty) -> output sequence and out_eof position identical to the gap-free run; latency 3 cycles after each completing pixel.
// - rst at pixel 37 -> out_valid low from the next cycle; a following full frame gives 64 correct outputs.

Source files
------------

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution over raster-order frames with double-buffered runtime coefficients.
// Three-stage pipeline (products, sum, shift/clamp) behind the line buffers and window register.
module conv2d_stream #(
  parameter int WORD_SIZE  = 8,
  parameter int COEF_WIDTH = 8,
  parameter int KSIZE      = 3,
  parameter int ROW_SIZE   = 10,
  parameter int COL_SIZE   = 10,
  localparam int NK    = KSIZE * KSIZE,
  localparam int AW    = $clog2(NK),
  localparam int ACC_W = WORD_SIZE + COEF_WIDTH + $clog2(NK) + 1,
  localparam int SW    = $clog2(ACC_W)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WORD_SIZE-1:0]         in_pixel,
  input  logic                         coef_we,
  input  logic [AW-1:0]                coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  input  logic                         coef_commit,
  input  logic [SW-1:0]                shift,
  output logic                         out_valid,
  output logic [WORD_SIZE-1:0]         out_pixel,
  output logic                         out_eof,
  output logic                         coef_pending
);

  localparam int CW = $clog2(ROW_SIZE);
  localparam int RW = $clog2(COL_SIZE);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << WORD_SIZE) - 1);

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic                 last_col, last_row, frame_start, copy_now;
  logic [WORD_SIZE-1:0] lbuf [KSIZE-1][ROW_SIZE];
  logic [WORD_SIZE-1:0] win  [KSIZE][KSIZE];

  logic signed [COEF_WIDTH-1:0] shadow    [NK];
  logic signed [COEF_WIDTH-1:0] active    [NK];
  logic signed [COEF_WIDTH-1:0] coef_prod [NK];

  logic signed [ACC_W-1:0] prod [NK];
  logic signed [ACC_W-1:0] sum_next, sum_q, shifted;
  logic [WORD_SIZE-1:0]    clamped;
  logic                    v0, e0, v1, e1, v2, e2;

  function automatic logic signed [COEF_WIDTH-1:0] def_coef(input int k);
    return (k == NK / 2) ? COEF_WIDTH'(NK - 1) : '1;
  endfunction

  assign last_col    = (col == CW'(ROW_SIZE - 1));
  assign last_row    = (row == RW'(COL_SIZE - 1));
  assign frame_start = (row == '0) && (col == '0);
  assign copy_now    = (coef_commit && frame_start) ||
                       (in_valid && last_row && last_col && (coef_pending || coef_commit));

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      v0  <= 1'b0;
      e0  <= 1'b0;
    end else begin
      v0 <= in_valid && (row >= RW'(KSIZE - 1)) && (col >= CW'(KSIZE - 1));
      e0 <= in_valid && last_row && last_col;
      if (in_valid) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Window row 0 is the oldest image row, column 0 the oldest column.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lbuf[0][col] <= in_pixel;
      for (int m = 1; m < KSIZE - 1; m++) lbuf[m][col] <= lbuf[m-1][col];
      for (int i = 0; i < KSIZE; i++)
        for (int j = 0; j < KSIZE - 1; j++) win[i][j] <= win[i][j+1];
      win[KSIZE-1][KSIZE-1] <= in_pixel;
      for (int m = 1; m < KSIZE; m++) win[KSIZE-1-m][KSIZE-1] <= lbuf[m-1][col];
    end
  end

  // coef_prod lags active by one edge so the window accepted on the swap edge
  // still multiplies with the coefficients of the frame it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NK; k++) begin
        shadow[k]    <= def_coef(k);
        active[k]    <= def_coef(k);
        coef_prod[k] <= def_coef(k);
      end
      coef_pending <= 1'b0;
    end else begin
      if (coef_we && (coef_addr < AW'(NK))) shadow[coef_addr] <= coef_data;
      for (int k = 0; k < NK; k++) begin
        if (copy_now) active[k] <= shadow[k];
        coef_prod[k] <= active[k];
      end
      if (copy_now)         coef_pending <= 1'b0;
      else if (coef_commit) coef_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE; j++)
        prod[i*KSIZE+j] <= $signed({{(ACC_W-WORD_SIZE){1'b0}}, win[i][j]}) *
                           $signed({{(ACC_W-COEF_WIDTH){coef_prod[i*KSIZE+j][COEF_WIDTH-1]}},
                                    coef_prod[i*KSIZE+j]});
    sum_q <= sum_next;
  end

  always_comb begin
    sum_next = '0;
    for (int k = 0; k < NK; k++) sum_next = sum_next + prod[k];
  end

  always_comb begin
    shifted = sum_q >>> shift;
    if (shifted[ACC_W-1])   clamped = '0;
    else if (shifted > MAXV) clamped = '1;
    else                    clamped = shifted[WORD_SIZE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      e1        <= 1'b0;
      v2        <= 1'b0;
      e2        <= 1'b0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      out_pixel <= '0;
    end else begin
      v1        <= v0;
      e1        <= e0;
      v2        <= v1;
      e2        <= e1;
      out_valid <= v2;
      out_eof   <= v2 && e2;
      if (v2) out_pixel <= clamped;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream (K=3, 10x10): frames with hand-derived outputs,
// coefficient swap timing, in_valid gaps and mid-frame reset.
module tb_conv2d_stream;

  localparam int W    = 8;
  localparam int K    = 3;
  localparam int RS   = 10;
  localparam int CS   = 10;
  localparam int NPIX = RS * CS;
  localparam int NOUT = (RS - K + 1) * (CS - K + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [W-1:0]      in_pixel;
  logic              coef_we;
  logic [3:0]        coef_addr;
  logic signed [7:0] coef_data;
  logic              coef_commit;
  logic [4:0]        shift;
  logic              out_valid;
  logic [W-1:0]      out_pixel;
  logic              out_eof;
  logic              coef_pending;

  conv2d_stream #(
    .WORD_SIZE(W), .COEF_WIDTH(8), .KSIZE(K), .ROW_SIZE(RS), .COL_SIZE(CS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .shift(shift), .out_valid(out_valid),
    .out_pixel(out_pixel), .out_eof(out_eof), .coef_pending(coef_pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int testCount = 0;
  int failCount = 0;

  logic [W-1:0] frame [NPIX];
  int           expOut [NOUT];
  logic [W-1:0] gotPix [$];
  logic         gotEof [$];
  int           gotCyc [$];
  int           expCyc [$];

  // Outputs are captured on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (out_valid) begin
      gotPix.push_back(out_pixel);
      gotEof.push_back(out_eof);
      gotCyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] pix, input int gaps, input int idx,
                               input logic commit);
    repeat (gaps) @(negedge clk);
    in_pixel    = pix;
    in_valid    = 1'b1;
    coef_commit = commit;
    @(negedge clk);
    in_valid    = 1'b0;
    coef_commit = 1'b0;
    if ((idx / RS) >= K - 1 && (idx % RS) >= K - 1) expCyc.push_back(cyc + 3);
  endtask

  task automatic runFrame(input int useGaps, input int commitAt);
    for (int idx = 0; idx < NPIX; idx++) begin
      applyStimulus(frame[idx], (useGaps != 0) ? int'($urandom_range(0, 1)) : 0, idx,
                    idx == commitAt);
      if (idx == commitAt) check("pending_set", 32'(coef_pending), 1);
      if (commitAt >= 0 && idx == NPIX - 2) check("pending_hold", 32'(coef_pending), 1);
      if (commitAt >= 0 && idx == NPIX - 1) check("pending_clear", 32'(coef_pending), 0);
    end
  endtask

  task automatic checkOutput(input string tag);
    repeat (6) @(negedge clk);
    check($sformatf("%s_count", tag), 32'(gotPix.size()), NOUT);
    for (int k = 0; k < NOUT; k++) begin
      check($sformatf("%s_pix%0d", tag, k),
            (k < gotPix.size()) ? 32'(gotPix[k]) : 'x, 32'(expOut[k]));
      check($sformatf("%s_eof%0d", tag, k),
            (k < gotEof.size()) ? 32'(gotEof[k]) : 'x, (k == NOUT - 1) ? 1 : 0);
      check($sformatf("%s_lat%0d", tag, k),
            (k < gotCyc.size()) ? 32'(gotCyc[k]) : 'x,
            (k < expCyc.size()) ? 32'(expCyc[k]) : 'x);
    end
    gotPix.delete(); gotEof.delete(); gotCyc.delete(); expCyc.delete();
  endtask

  task automatic writeCoef(input int addr, input int data);
    coef_we   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = 8'(data);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; coef_we = 1'b0; coef_addr = '0;
    coef_data = '0; coef_commit = 1'b0; shift = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_eof", 32'(out_eof), 0);
    check("rst_out_pixel", 32'(out_pixel), 0);
    check("rst_pending", 32'(coef_pending), 0);
    rst = 1'b0;
    @(negedge clk);

    // Constant 100 through the default Laplacian sums to zero everywhere.
    for (int i = 0; i < NPIX; i++) frame[i] = 8'd100;
    for (int k = 0; k < NOUT; k++) expOut[k] = 0;
    runFrame(0, -1);
    checkOutput("const100");

    // Impulse 255 at (5,5): centre window 2040 -> 255, neighbours -255 -> 0.
    for (int i = 0; i < NPIX; i++) frame[i] = 8'd0;
    frame[5 * RS + 5] = 8'd255;
    for (int k = 0; k < NOUT; k++) expOut[k] = (k == 36) ? 255 : 0;
    runFrame(0, -1);
    checkOutput("impulse");

    // All-ones in shadow, committed mid-frame: this frame stays Laplacian, next gives 90.
    for (int a = 0; a < 9; a++) writeCoef(a, 1);
    shift = 5'd3;
    for (int i = 0; i < NPIX; i++) frame[i] = 8'd80;
    for (int k = 0; k < NOUT; k++) expOut[k] = 0;
    runFrame(0, 20);
    checkOutput("midcommit");
    for (int k = 0; k < NOUT; k++) expOut[k] = 90;
    runFrame(0, -1);
    checkOutput("ones80");

    // Idle commit with a simultaneous write: active gets the pre-write tap (1), shadow gets 5.
    for (int a = 1; a < 9; a++) writeCoef(a, 0);
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'sd5; coef_commit = 1'b1;
    @(negedge clk);
    coef_we = 1'b0; coef_commit = 1'b0;
    check("idle_commit_pending", 32'(coef_pending), 0);
    shift = 5'd0;
    for (int i = 0; i < NPIX; i++) frame[i] = 8'((i / RS) * 10 + (i % RS));
    for (int k = 0; k < NOUT; k++) expOut[k] = (k / 8) * 10 + (k % 8);
    runFrame(1, -1);
    checkOutput("topleft_gaps");

    // Second idle commit exposes the written 5: 5*pixel, clamped at 255.
    coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
    for (int k = 0; k < NOUT; k++)
      expOut[k] = (5 * ((k / 8) * 10 + (k % 8)) > 255) ? 255 : 5 * ((k / 8) * 10 + (k % 8));
    runFrame(0, -1);
    checkOutput("tap5_clamp");

    // Reset after pixel 37 of a frame with a pending commit.
    for (int i = 0; i < NPIX; i++) frame[i] = 8'd100;
    for (int idx = 0; idx < 37; idx++) applyStimulus(frame[idx], 0, idx, idx == 10);
    check("pre_rst_pending", 32'(coef_pending), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_eof", 32'(out_eof), 0);
    check("midrst_out_pixel", 32'(out_pixel), 0);
    check("midrst_pending", 32'(coef_pending), 0);
    rst = 1'b0;
    gotPix.delete(); gotEof.delete(); gotCyc.delete(); expCyc.delete();
    @(negedge clk);
    check("post_rst_quiet", 32'(gotPix.size()), 0);
    for (int k = 0; k < NOUT; k++) expOut[k] = 0;
    runFrame(0, -1);
    checkOutput("after_rst");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
